mem_access_ctrl: RTL and testbench

- Initiator side of the block-RAM read/write/ready interface.
- Sits between the LC-3 control FSM (MAR/MDR path) and the memory: accepts one read or write request and drives the memory enables, address and write data.
- Waits for the memory's ready bit, captures read data, and returns a one-cycle completion pulse.
- Bounds every access with a timeout so a stuck memory cannot hang the CPU.

---
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Block-RAM request/ready bus between the access controller (master) and the memory (slave).
interface mem_access_ctrl_if #(
  parameter int AddrBusSize = 16,
  parameter int ElementSize = 16
);
  logic                   o_mem_write_en;
  logic                   o_mem_read_en;
  logic [AddrBusSize-1:0] o_mem_write_addr;
  logic [AddrBusSize-1:0] o_mem_read_addr;
  logic [ElementSize-1:0] o_mem_write_data;
  logic                   i_mem_ready;
  logic [ElementSize-1:0] i_mem_rdata;

  modport master (
    output o_mem_write_en, o_mem_read_en, o_mem_write_addr, o_mem_read_addr, o_mem_write_data,
    input  i_mem_ready, i_mem_rdata
  );

  modport slave (
    input  o_mem_write_en, o_mem_read_en, o_mem_write_addr, o_mem_read_addr, o_mem_write_data,
    output i_mem_ready, i_mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for one block-RAM read or write per request: drives enables until ready,
// captures read data, pulses done or timeout, then drains a lingering ready.
module mem_access_ctrl #(
  parameter int AddrBusSize   = 16,
  parameter int ElementSize   = 16,
  parameter int TimeoutCycles = 15
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   i_start,
  input  logic                   i_rw,
  input  logic [AddrBusSize-1:0] i_addr,
  input  logic [ElementSize-1:0] i_wdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic [ElementSize-1:0] o_rdata,
  mem_access_ctrl_if.master      mem
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [CntW-1:0]        cnt_r, cnt_s;
  logic                   we_r, we_s;
  logic                   re_r, re_s;
  logic [AddrBusSize-1:0] addr_r, addr_s;
  logic [ElementSize-1:0] wdata_r, wdata_s;
  logic [ElementSize-1:0] rdata_r, rdata_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic                   timeout_r, timeout_s;

  // Next-state and next-output computation for every registered output.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    we_s      = we_r;
    re_s      = re_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    rdata_s   = rdata_r;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          addr_s  = i_addr;
          wdata_s = i_wdata;
          we_s    = i_rw;
          re_s    = ~i_rw;
          cnt_s   = {CntW{1'b0}};
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Ready wins over a timeout expiring on the same edge.
        if (mem.i_mem_ready) begin
          if (re_r) begin
            rdata_s = mem.i_mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          we_s    = 1'b0;
          re_s    = 1'b0;
          done_s  = 1'b1;
          cnt_s   = {CntW{1'b0}};
          state_s = DRAIN;
        end else if (cnt_r == CntLast) begin
          we_s      = 1'b0;
          re_s      = 1'b0;
          timeout_s = 1'b1;
          cnt_s     = {CntW{1'b0}};
          state_s   = DRAIN;
        end else begin
          cnt_s = cnt_r + CntOne;
        end
      end
      DRAIN: begin
        // A ready still high from the finished access must not ack the next one.
        if (!mem.i_mem_ready || (cnt_r == CntLast)) begin
          cnt_s   = {CntW{1'b0}};
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CntOne;
        end
      end
      default: begin
        we_s    = 1'b0;
        re_s    = 1'b0;
        cnt_s   = {CntW{1'b0}};
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_r   <= IDLE;
      cnt_r     <= {CntW{1'b0}};
      we_r      <= 1'b0;
      re_r      <= 1'b0;
      addr_r    <= {AddrBusSize{1'b0}};
      wdata_r   <= {ElementSize{1'b0}};
      rdata_r   <= {ElementSize{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      we_r      <= we_s;
      re_r      <= re_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      rdata_r   <= rdata_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
    end
  end

  assign o_busy               = busy_r;
  assign o_done               = done_r;
  assign o_timeout            = timeout_r;
  assign o_rdata              = rdata_r;
  assign mem.o_mem_write_en   = we_r;
  assign mem.o_mem_read_en    = re_r;
  assign mem.o_mem_write_addr = addr_r;
  assign mem.o_mem_read_addr  = addr_r;
  assign mem.o_mem_write_data = wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a one-cycle-latency block-RAM model and
// a scoreboard of expected completions.
module tb_mem_access_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          i_CLK = 1'b0;
  logic          i_RST;
  logic          i_start;
  logic          i_rw;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout;
  logic [DW-1:0] o_rdata;

  mem_access_ctrl_if #(.AddrBusSize(AW), .ElementSize(DW)) mif ();

  mem_access_ctrl #(.AddrBusSize(AW), .ElementSize(DW), .TimeoutCycles(15)) dut (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_start   (i_start),
    .i_rw      (i_rw),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_timeout (o_timeout),
    .o_rdata   (o_rdata),
    .mem       (mif)
  );

  always #5 i_CLK = ~i_CLK;

  // Memory model: ready one edge after an enable is seen, then drops.
  logic          mready_r;
  logic [DW-1:0] mrdata_r;
  logic [DW-1:0] mem_array [0:255];
  logic          never_ready;
  logic          force_hi;

  always @(posedge i_CLK) begin
    if (i_RST) begin
      mready_r <= 1'b0;
    end else if ((mif.o_mem_write_en || mif.o_mem_read_en) && !mready_r) begin
      mready_r <= 1'b1;
      if (mif.o_mem_write_en) mem_array[mif.o_mem_write_addr[7:0]] <= mif.o_mem_write_data;
      mrdata_r <= mem_array[mif.o_mem_read_addr[7:0]];
    end else begin
      mready_r <= 1'b0;
    end
  end

  assign mif.i_mem_ready = force_hi | (mready_r & ~never_ready);
  assign mif.i_mem_rdata = mrdata_r;

  typedef struct {
    logic [1:0]  kind;     // {done, timeout}
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          en_cycles;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] exp_rdata;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic is_timeout, input int en_cycles);
    exp_t e;
    i_rw    = rw;
    i_addr  = addr;
    i_wdata = wdata;
    i_start = 1'b1;
    if (!is_timeout && !rw) exp_rdata = ref_mem[addr];
    if (!is_timeout && rw) ref_mem[addr] = wdata;
    e.kind      = is_timeout ? 2'b01 : 2'b10;
    e.rdata     = exp_rdata;
    e.addr      = addr;
    e.wdata     = wdata;
    e.en_cycles = en_cycles;
    sb.push_back(e);
  endtask

  task automatic wait_completion(input bit hold, input int budget);
    exp_t e;
    int   en_cnt = 0;
    bit   got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge i_CLK);
      if (!hold) i_start = 1'b0;
      if (mif.o_mem_write_en && mif.o_mem_read_en) check("both_enables", 32'd1, 32'd0);
      if (mif.o_mem_write_en || mif.o_mem_read_en) en_cnt++;
      if (o_done || o_timeout) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check("spurious_completion", 32'({o_done, o_timeout}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("completion_kind", 32'({o_done, o_timeout}), 32'(e.kind));
          check("rdata_at_completion", 32'(o_rdata), 32'(e.rdata));
          check("enable_cycles", 32'(en_cnt), 32'(e.en_cycles));
          check("addr_held", 32'(mif.o_mem_write_addr), 32'(e.addr));
          check("raddr_held", 32'(mif.o_mem_read_addr), 32'(e.addr));
          check("wdata_held", 32'(mif.o_mem_write_data), 32'(e.wdata));
        end
      end
    end
    if (!got) check("completion_within_budget", 32'd0, 32'd1);
  endtask

  initial begin
    i_RST = 1'b1; i_start = 1'b0; i_rw = 1'b0; i_addr = 16'h0000; i_wdata = 16'h0000;
    never_ready = 1'b0; force_hi = 1'b0; exp_rdata = 16'h0000;

    // Reset state
    repeat (3) @(negedge i_CLK);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_we", 32'(mif.o_mem_write_en), 32'd0);
    check("rst_re", 32'(mif.o_mem_read_en), 32'd0);
    check("rst_rdata", 32'(o_rdata), 32'd0);
    check("rst_addr", 32'(mif.o_mem_write_addr), 32'd0);
    check("rst_wdata", 32'(mif.o_mem_write_data), 32'd0);
    i_RST = 1'b0;

    // Write 0xBEEF to 0x0010
    @(negedge i_CLK);
    issue(1'b1, 16'h0010, 16'hBEEF, 1'b0, 2);
    wait_completion(1'b0, 20);
    @(negedge i_CLK);
    check("write_done_single", 32'(o_done), 32'd0);
    check("write_busy_low", 32'(o_busy), 32'd0);

    // Read it back; value must persist
    @(negedge i_CLK);
    issue(1'b0, 16'h0010, 16'h0000, 1'b0, 2);
    wait_completion(1'b0, 20);
    repeat (10) @(negedge i_CLK);
    check("rdata_hold", 32'(o_rdata), 32'h0000BEEF);

    // Back-to-back with i_start held high
    @(negedge i_CLK);
    issue(1'b1, 16'h0001, 16'h1111, 1'b0, 2);
    wait_completion(1'b1, 20);
    issue(1'b1, 16'h0002, 16'h2222, 1'b0, 2);
    wait_completion(1'b1, 20);
    issue(1'b0, 16'h0001, 16'h0000, 1'b0, 2);
    wait_completion(1'b1, 20);
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_CLK);
      check("b2b_quiet", 32'({mif.o_mem_write_en, mif.o_mem_read_en, o_done, o_timeout}), 32'd0);
    end
    check("b2b_idle", 32'(o_busy), 32'd0);

    // Memory never answers
    @(negedge i_CLK);
    never_ready = 1'b1;
    issue(1'b0, 16'h0002, 16'h0000, 1'b1, 15);
    wait_completion(1'b0, 40);
    @(negedge i_CLK);
    check("timeout_idle", 32'(o_busy), 32'd0);
    check("timeout_rdata_kept", 32'(o_rdata), 32'h00001111);
    check("timeout_no_done", 32'(o_done), 32'd0);
    repeat (2) @(negedge i_CLK);
    never_ready = 1'b0;

    // Ready stuck high in DRAIN; i_start must be ignored there
    @(negedge i_CLK);
    issue(1'b1, 16'h0003, 16'h3333, 1'b0, 2);
    wait_completion(1'b0, 20);
    force_hi = 1'b1;
    i_rw = 1'b0; i_addr = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_CLK);
      check("drain_busy", 32'(o_busy), 32'd1);
      check("drain_no_accept", 32'({mif.o_mem_write_en, mif.o_mem_read_en, o_done}), 32'd0);
      i_start = (i < 3) ? 1'b1 : 1'b0;
    end
    force_hi = 1'b0;
    @(negedge i_CLK);
    check("drain_exit_idle", 32'(o_busy), 32'd0);
    check("drain_exit_no_en", 32'({mif.o_mem_write_en, mif.o_mem_read_en}), 32'd0);

    // Reset one cycle into a read
    @(negedge i_CLK);
    i_rw = 1'b0; i_addr = 16'h0001; i_start = 1'b1;
    @(negedge i_CLK);
    i_start = 1'b0;
    check("mid_read_en", 32'(mif.o_mem_read_en), 32'd1);
    i_RST = 1'b1;
    @(negedge i_CLK);
    check("mid_rst_en", 32'({mif.o_mem_write_en, mif.o_mem_read_en}), 32'd0);
    check("mid_rst_pulses", 32'({o_done, o_timeout}), 32'd0);
    check("mid_rst_rdata", 32'(o_rdata), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    i_RST = 1'b0;
    exp_rdata = 16'h0000;
    @(negedge i_CLK);
    issue(1'b0, 16'h0001, 16'h0000, 1'b0, 2);
    wait_completion(1'b0, 20);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
